// File: rtl/trap_pkg.sv
// Shared trap_ctrl definitions: cause codes, mtvec modes, FSM states and arbitration result.
package trap_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_IMIS  = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILL   = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BRK   = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LMIS  = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_SMIS  = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL = 4'd11;
    localparam logic [CAUSE_W-1:0] CAUSE_MSI   = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MTI   = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI   = 4'd11;

    localparam logic [1:0] MTVEC_DIRECT = 2'b00;
    localparam logic [1:0] MTVEC_VECT   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRAP_SET  = 2'd1,
        ST_TRAP_JUMP = 2'd2,
        ST_MRET_JUMP = 2'd3
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [CAUSE_W-1:0] cause;
        logic               i_or_e;
    } trap_req_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority trap arbiter: exceptions first, then globally enabled pending interrupts.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic      instr_misalign_in,
    input  logic      illegal_instr_in,
    input  logic      ebreak_in,
    input  logic      ecall_in,
    input  logic      load_misalign_in,
    input  logic      store_misalign_in,
    input  logic      meip_in,
    input  logic      msip_in,
    input  logic      mtip_in,
    input  logic      meie_in,
    input  logic      msie_in,
    input  logic      mtie_in,
    input  logic      mstatus_mie_in,
    output trap_req_t req_c
);

    always_comb begin
        req_c = '0;
        if (instr_misalign_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_IMIS, i_or_e: 1'b0};
        end else if (illegal_instr_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_ILL, i_or_e: 1'b0};
        end else if (ebreak_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_BRK, i_or_e: 1'b0};
        end else if (ecall_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_ECALL, i_or_e: 1'b0};
        end else if (load_misalign_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_LMIS, i_or_e: 1'b0};
        end else if (store_misalign_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_SMIS, i_or_e: 1'b0};
        end else if (mstatus_mie_in && meip_in && meie_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_MEI, i_or_e: 1'b1};
        end else if (mstatus_mie_in && msip_in && msie_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_MSI, i_or_e: 1'b1};
        end else if (mstatus_mie_in && mtip_in && mtie_in) begin
            req_c = '{valid: 1'b1, cause: CAUSE_MTI, i_or_e: 1'b1};
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates traps/MRET, drives mcause/mepc/mstatus
// strobes and stalls, flushes and redirects fetch.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                rst_n_in,
    input  logic                instr_valid_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic                instr_misalign_in,
    input  logic                illegal_instr_in,
    input  logic                ebreak_in,
    input  logic                load_misalign_in,
    input  logic                store_misalign_in,
    input  logic                ecall_in,
    input  logic                mret_in,
    input  logic                meip_in,
    input  logic                msip_in,
    input  logic                mtip_in,
    input  logic                meie_in,
    input  logic                msie_in,
    input  logic                mtie_in,
    input  logic                mstatus_mie_in,
    input  logic [XLEN-1:0]     mtvec_in,
    input  logic [XLEN-1:0]     mepc_in,
    output logic                set_cause_out,
    output logic [CAUSE_W-1:0]  cause_out,
    output logic                i_or_e_out,
    output logic                set_epc_out,
    output logic [XLEN-1:0]     epc_out,
    output logic                mie_clear_out,
    output logic                mie_restore_out,
    output logic                stall_out,
    output logic                flush_out,
    output logic                redirect_valid_out,
    output logic [XLEN-1:0]     redirect_pc_out,
    output logic                busy_out
);

    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_e             state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               i_or_e_q, i_or_e_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic               stall_c;
    logic               vect_c;
    trap_req_t          req_c;

    trap_prio_enc u_prio (
        .instr_misalign_in (instr_misalign_in),
        .illegal_instr_in  (illegal_instr_in),
        .ebreak_in         (ebreak_in),
        .ecall_in          (ecall_in),
        .load_misalign_in  (load_misalign_in),
        .store_misalign_in (store_misalign_in),
        .meip_in           (meip_in),
        .msip_in           (msip_in),
        .mtip_in           (mtip_in),
        .meie_in           (meie_in),
        .msie_in           (msie_in),
        .mtie_in           (mtie_in),
        .mstatus_mie_in    (mstatus_mie_in),
        .req_c             (req_c)
    );

    always_ff @(posedge clock or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            i_or_e_q <= 1'b0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            i_or_e_q <= i_or_e_d;
            epc_q    <= epc_d;
        end
    end

    assign vect_c = VECTORED_EN && (mtvec_in[1:0] == MTVEC_VECT) && i_or_e_q;

    always_comb begin
        state_d            = state_q;
        cause_d            = cause_q;
        i_or_e_d           = i_or_e_q;
        epc_d              = epc_q;
        stall_c            = 1'b0;
        set_cause_out      = 1'b0;
        set_epc_out        = 1'b0;
        mie_clear_out      = 1'b0;
        mie_restore_out    = 1'b0;
        flush_out          = 1'b0;
        redirect_valid_out = 1'b0;
        redirect_pc_out    = RESET_PC;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid_in && req_c.valid) begin
                    state_d  = ST_TRAP_SET;
                    cause_d  = req_c.cause;
                    i_or_e_d = req_c.i_or_e;
                    epc_d    = pc_in & ALIGN_MASK;
                    stall_c  = 1'b1;
                end else if (instr_valid_in && mret_in) begin
                    state_d = ST_MRET_JUMP;
                    stall_c = 1'b1;
                end
            end
            ST_TRAP_SET: begin
                set_cause_out = 1'b1;
                set_epc_out   = 1'b1;
                mie_clear_out = 1'b1;
                stall_c       = 1'b1;
                state_d       = ST_TRAP_JUMP;
            end
            ST_TRAP_JUMP: begin
                redirect_valid_out = 1'b1;
                flush_out          = 1'b1;
                stall_c            = 1'b1;
                // Vector offset is cause*4; the 32-bit add wraps.
                redirect_pc_out    = (mtvec_in & ALIGN_MASK)
                                   + (vect_c ? XLEN'({cause_q, 2'b00}) : '0);
                state_d            = ST_IDLE;
            end
            ST_MRET_JUMP: begin
                mie_restore_out    = 1'b1;
                redirect_valid_out = 1'b1;
                flush_out          = 1'b1;
                stall_c            = 1'b1;
                redirect_pc_out    = mepc_in & ALIGN_MASK;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The IDLE stall follows live request inputs, so it is masked while reset is held.
    assign stall_out  = stall_c && rst_n_in;
    assign cause_out  = cause_q;
    assign i_or_e_out = i_or_e_q;
    assign epc_out    = epc_q;
    assign busy_out   = (state_q != ST_IDLE);

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer for the RV32 core.
- Arbitrates synchronous exceptions and pending interrupts, then drives the mcause CSR update (set_cause / cause / int-or-exc), mepc capture and mstatus.MIE save/restore.
- Stalls and flushes the pipeline and redirects fetch to mtvec, or to mepc on MRET.
- Sits between decode/execute and the CSR file.

Parameters:
- VECTORED_EN, 1, when 1 honour mtvec mode 01 (vectored) for interrupts; when 0 always use direct mode.
- RESET_PC, 32'h0000_0000, value driven on redirect_pc_out while in reset or idle.

Ports:
- clock  in  1  core clock
- rst_n_in  in  1  asynchronous active-low reset
- instr_valid_in  in  1  instruction in execute is valid and may commit
- pc_in  in  32  PC of the instruction in execute
- instr_misalign_in  in  1  instruction address misaligned (cause 0)
- illegal_instr_in  in  1  illegal instruction (cause 2)
- ebreak_in  in  1  EBREAK (cause 3)
- load_misalign_in  in  1  load address misaligned (cause 4)
- store_misalign_in  in  1  store address misaligned (cause 6)
- ecall_in  in  1  ECALL from M-mode (cause 11)
- mret_in  in  1  MRET in execute
- meip_in, msip_in, mtip_in  in  1 each  interrupt pending lines
- meie_in, msie_in, mtie_in  in  1 each  mie enable bits
- mstatus_mie_in  in  1  global interrupt enable
- mtvec_in  in  32  trap vector (bits [1:0] = mode)
- mepc_in  in  32  current mepc
- set_cause_out  out  1  one-cycle strobe to the mcause register
- cause_out  out  4  cause code
- i_or_e_out  out  1  1 = interrupt, 0 = exception
- set_epc_out  out  1  one-cycle strobe writing epc_out into mepc
- epc_out  out  32  captured PC (word-aligned, bits [1:0] = 0)
- mie_clear_out  out  1  strobe: MPIE <= MIE, MIE <= 0
- mie_restore_out  out  1  strobe: MIE <= MPIE, MPIE <= 1
- stall_out  out  1  freeze fetch/decode/execute
- flush_out  out  1  kill IF/ID contents
- redirect_valid_out  out  1  fetch must load redirect_pc_out
- redirect_pc_out  out  32  target PC
- busy_out  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, rst_n_in low): state IDLE; every strobe, stall, flush, valid and busy output = 0; cause_out = 0; i_or_e_out = 0; epc_out = 0; redirect_pc_out = RESET_PC. Reset asserted mid-sequence aborts the sequence immediately; no partial strobe is emitted after release.
- States: IDLE, TRAP_SET, TRAP_JUMP, MRET_JUMP.
- IDLE, sampled only when instr_valid_in = 1. Arbitration priority:
  - Exceptions first, in this order: instr_misalign > illegal > ebreak > ecall > load_misalign > store_misalign.
  - Then interrupts, only when mstatus_mie_in = 1 and the line is both pending and enabled: MEI (11) > MSI (3) > MTI (7).
  - Then mret_in.
- On a win in cycle N:
  - Latch cause, i_or_e and epc = {pc_in[31:2], 2'b00}.
  - Go to TRAP_SET, or to MRET_JUMP for MRET.
  - stall_out asserts combinationally in cycle N.
- TRAP_SET (cycle N+1):
  - set_cause_out, set_epc_out and mie_clear_out high for exactly this cycle.
  - stall_out = 1. Next state TRAP_JUMP.
- TRAP_JUMP (cycle N+2):
  - redirect_valid_out = 1 and flush_out = 1 for one cycle; stall_out = 1.
  - redirect_pc_out = {mtvec_in[31:2], 2'b00} when direct mode, or for any exception.
  - redirect_pc_out = {mtvec_in[31:2], 2'b00} + (cause << 2) when VECTORED_EN = 1, mtvec_in[1:0] = 01 and the trap is an interrupt. The 32-bit add wraps silently.
  - Next state IDLE.
- MRET_JUMP (cycle N+1):
  - mie_restore_out = 1, redirect_valid_out = 1, flush_out = 1, stall_out = 1, redirect_pc_out = {mepc_in[31:2], 2'b00}.
  - Next state IDLE.
- Trap latency: 2 cycles to redirect. MRET latency: 1 cycle.
- Requests arriving while not in IDLE are ignored. The stall holds them stable; they are re-arbitrated in IDLE.
- An interrupt is taken on the instruction in execute, which does not commit; mepc = its PC.
- Simultaneous exception and MRET: the exception wins and MRET is discarded.
- mtvec_in and mepc_in are sampled in the redirect cycle, so a CSR write completed in TRAP_SET is visible.
- cause_out, i_or_e_out and epc_out hold their latched values until the next accepted trap.
- busy_out = (state != IDLE).

Decomposition:
- Shared package trap_pkg:
  - cause codes: CAUSE_IMIS = 0, CAUSE_ILL = 2, CAUSE_BRK = 3, CAUSE_LMIS = 4, CAUSE_SMIS = 6, CAUSE_ECALL = 11, CAUSE_MSI = 3, CAUSE_MTI = 7, CAUSE_MEI = 11
  - state encodings
  - MTVEC_DIRECT = 2'b00, MTVEC_VECT = 2'b01
- One sub-module: trap_prio_enc, a purely combinational fixed-priority encoder returning valid, cause and i_or_e. The FSM stays in trap_ctrl.

Test Plan:
- Illegal instr at pc = 0x0000_0104, mtvec = 0x0000_0200 → N+1: set_cause = 1, cause = 2, i_or_e = 0, epc = 0x104, mie_clear = 1; N+2: redirect_pc = 0x200, flush = 1.
- MTI pending, mtie = 1, mstatus_mie = 1, mtvec = 0x0000_1001 (vectored) → cause = 7, i_or_e = 1, redirect_pc = 0x101C.
- ecall + meip + mret in the same cycle → exception wins: cause = 11, i_or_e = 0, no mie_restore.
- mret_in, mepc = 0x0000_0346 → N+1: redirect_pc = 0x344, mie_restore = 1, set_cause never asserted.
- MEI pending but mstatus_mie = 0 → no trap, stall = 0; raise mstatus_mie → trap with cause 11 on the next valid instruction.
- rst_n_in pulled low during TRAP_SET → all outputs 0 immediately; after release the FSM is IDLE and set_cause / redirect never fire for the aborted trap.
